faccel_p: RTL and testbench
===========================

Name: faccel_p

Overview:
- Parametrised, memory-mapped iterative factorial accelerator on the processor's 2-bit-address register bus.
- Generalises operand and result width over the fixed 4-bit/32-bit version.
- Adds a busy flag, overflow detection, write-1-to-clear done/error, busy-safe go handling, and an optional interrupt.
- Sits beside the data memory and is selected by the system address decoder.

Parameters:
- NW, 4, operand n width in bits; minimum 3; also the bus write-data width.
- OW, 32, result width and bus read-data width; OW >= NW + 3.

Ports:
- Clk  input  1  single system clock; all state changes on its rising edge.
- Rst  input  1  asynchronous, active-low reset; Rst=0 clears all state immediately.
- we  input  1  bus write enable.
- a  input  2  register address.
- d  input  NW  bus write data.
- out  output  OW  combinational read data for address a.
- irq  output  1  interrupt; present only with FACCEL_IRQ_EN.

Behaviour:
- Register map:
  - 0 N: RW, bits NW-1:0.
  - 1 CTRL: write bit0=go (self-clearing pulse), bit1=ie (stored); reads {0, ie, busy}.
  - 2 STATUS: reads {0, err, busy, done}; writing bit0=1 clears done and err.
  - 3 RESULT: RO, OW bits.
- Reset (Rst=0): N=0, ie=0, done=0, err=0, busy=0, RESULT=0, engine state IDLE, irq=0.
- out is purely combinational from a and register state. A read has no side effects.
- Start: a go pulse is we=1, a=1, d[0]=1 with busy=0. At that edge:
  - the engine latches cnt=N and acc=1;
  - busy sets; done and err clear;
  - ie updates from d[1].
- A go pulse with busy=1 is ignored. ie still updates, and the run continues unaffected.
- Writing N while busy=1 is allowed. The run uses its latched copy.
- Engine states:
  - IDLE: go -> MUL.
  - MUL, each edge:
    - cnt<=1: RESULT<=acc, done<=1, busy<=0 -> IDLE.
    - otherwise, compute p=acc*cnt at full 2*OW width.
    - If p[2*OW-1:OW] is nonzero: err<=1, done<=1, RESULT<=0, busy<=0 -> IDLE.
    - Else acc<=p[OW-1:0] and cnt<=cnt-1.
- Latency: done reads 1 exactly max(N,1)+1 cycles after the go edge.
  - N=0 and N=1 both give RESULT=1 after 2 cycles.
- RESULT changes only at the completing edge. It holds between runs.
- Simultaneous STATUS clear write and completion at the same edge: completion wins (done=1).
- Asserting Rst mid-run aborts the run. No done is produced and all outputs return to reset values.
- A new run after done does not need a prior clear: go clears done and err itself.

Optional Feature:
- Macro: FACCEL_IRQ_EN.
- Defined: port irq=ie & done, registered.
  - Cleared by the STATUS bit0 write, by a new go, or by reset.
  - Rises on the cycle done sets when ie=1.
- Undefined: no irq port. ie is still stored and readable in CTRL bit1, with no other effect.

Decomposition:
- Shared package faccel_pkg holds:
  - address constants A_N=0, A_CTRL=1, A_STATUS=2, A_RESULT=3;
  - CTRL/STATUS bit-index constants;
  - engine state encoding IDLE/MUL.
- One sub-module, fact_engine #(NW,OW). It contains cnt, acc, the overflow check and the FSM, and exposes:
  - inputs start, n;
  - outputs busy, fin, ovf, acc.
- Top level keeps the address decode, N/ie/done/err/RESULT registers and the read mux.

Test Plan:
- Reset: drive Rst=0 mid-run with N=5 -> all four registers read 0 immediately. irq=0 and no later done.
- N=5, go: busy=1 for the run. done=1 six cycles after the go edge. RESULT=120, err=0.
- N=0 then N=1 runs: each gives done after 2 cycles and RESULT=1.
- OW=32, N=12 -> RESULT=479001600, err=0. N=13 -> err=1, done=1, RESULT=0.
- Second go three cycles into an N=7 run: ignored. Done arrives on the original schedule with RESULT=5040. Writing N=3 mid-run does not alter the result.
- With FACCEL_IRQ_EN: go with d=3'b011 and N=4 -> irq rises with done and RESULT=24. STATUS write of 1 -> irq=0, done=0. Repeat with ie=0 -> irq stays 0.

Source files
------------

// File: rtl/faccel_pkg.sv
// Shared constants for the factorial accelerator: register map, bit positions, engine states.
package faccel_pkg;

  localparam logic [1:0] A_N      = 2'd0;
  localparam logic [1:0] A_CTRL   = 2'd1;
  localparam logic [1:0] A_STATUS = 2'd2;
  localparam logic [1:0] A_RESULT = 2'd3;

  localparam int CTRL_GO   = 0;
  localparam int CTRL_IE   = 1;
  localparam int CTRL_BUSY = 0;

  localparam int ST_DONE = 0;
  localparam int ST_BUSY = 1;
  localparam int ST_ERR  = 2;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } eng_state_t;

endpackage

// File: rtl/faccel_p_fact_engine.sv
// Iterative multiply engine: acc walks n*(n-1)*...*2, flags overflow of the OW-bit accumulator.
//  state | meaning
//  IDLE  | waiting for start; fin/ovf pulse here for one cycle after a run
//  MUL   | one multiply step per cycle until cnt<=1 or overflow
module fact_engine
  import faccel_pkg::*;
#(
  parameter int NW = 4,
  parameter int OW = 32
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          start,
  input  logic [NW-1:0] n,
  output logic          busy,
  output logic          fin,
  output logic          ovf,
  output logic [OW-1:0] acc
);

  eng_state_t      state_q, state_d;
  logic [NW-1:0]   cnt_q, cnt_d;
  logic [OW-1:0]   acc_q, acc_d;
  logic            fin_q, fin_d;
  logic            ovf_q, ovf_d;
  logic [2*OW-1:0] p;
  logic            last;
  logic            hi_nz;

  assign p     = {{OW{1'b0}}, acc_q} * {{(2*OW-NW){1'b0}}, cnt_q};
  assign last  = (cnt_q <= NW'(1));
  assign hi_nz = |p[2*OW-1:OW];

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      fin_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      fin_q   <= fin_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = MUL;
      MUL:     if (last || hi_nz) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    acc_d = acc_q;
    fin_d = 1'b0;
    ovf_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          cnt_d = n;
          acc_d = OW'(1);
        end
      end
      MUL: begin
        if (last) begin
          fin_d = 1'b1;
        end else if (hi_nz) begin
          fin_d = 1'b1;
          ovf_d = 1'b1;
        end else begin
          acc_d = p[OW-1:0];
          cnt_d = cnt_q - NW'(1);
        end
      end
      default: ;
    endcase
  end

  // fin_q keeps busy high until the top has captured the result
  assign busy = (state_q == MUL) | fin_q;
  assign fin  = fin_q;
  assign ovf  = ovf_q;
  assign acc  = acc_q;

endmodule

// File: rtl/faccel_p.sv
// Memory-mapped factorial accelerator: N/CTRL/STATUS/RESULT registers around fact_engine.
// Define FACCEL_IRQ_EN to add the registered irq output (ie & done).
module faccel_p
  import faccel_pkg::*;
#(
  parameter int NW = 4,
  parameter int OW = 32
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          we,
  input  logic [1:0]    a,
  input  logic [NW-1:0] d,
`ifdef FACCEL_IRQ_EN
  output logic          irq,
`endif
  output logic [OW-1:0] out
);

  logic [NW-1:0] n_q, n_d;
  logic          ie_q, ie_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [OW-1:0] res_q, res_d;
  logic          busy, fin, ovf;
  logic [OW-1:0] acc;
  logic          wr_ctrl, start, clr;

  assign wr_ctrl = we && (a == A_CTRL);
  assign start   = wr_ctrl && d[CTRL_GO] && !busy;
  assign clr     = we && (a == A_STATUS) && d[ST_DONE];

  fact_engine #(.NW(NW), .OW(OW)) u_engine (
    .Clk   (Clk),
    .Rst   (Rst),
    .start (start),
    .n     (n_q),
    .busy  (busy),
    .fin   (fin),
    .ovf   (ovf),
    .acc   (acc)
  );

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      n_q    <= '0;
      ie_q   <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      res_q  <= '0;
    end else begin
      n_q    <= n_d;
      ie_q   <= ie_d;
      done_q <= done_d;
      err_q  <= err_d;
      res_q  <= res_d;
    end
  end

  // completion takes priority over a same-cycle STATUS clear
  always_comb begin
    n_d    = (we && (a == A_N)) ? d : n_q;
    ie_d   = wr_ctrl ? d[CTRL_IE] : ie_q;
    done_d = done_q;
    err_d  = err_q;
    res_d  = res_q;
    if (start) begin
      done_d = 1'b0;
      err_d  = 1'b0;
    end else if (fin) begin
      done_d = 1'b1;
      err_d  = ovf;
      res_d  = ovf ? '0 : acc;
    end else if (clr) begin
      done_d = 1'b0;
      err_d  = 1'b0;
    end
  end

`ifdef FACCEL_IRQ_EN
  logic irq_q;
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) irq_q <= 1'b0;
    else      irq_q <= ie_d & done_d;
  end
  assign irq = irq_q;
`endif

  always_comb begin
    out = '0;
    case (a)
      A_N:      out = {{(OW-NW){1'b0}}, n_q};
      A_CTRL: begin
        out[CTRL_BUSY] = busy;
        out[CTRL_IE]   = ie_q;
      end
      A_STATUS: begin
        out[ST_DONE] = done_q;
        out[ST_BUSY] = busy;
        out[ST_ERR]  = err_q;
      end
      default:  out = res_q;
    endcase
  end

endmodule

// File: tb/tb_faccel_p.sv
// Directed bench for faccel_p (NW=4, OW=32); covers the irq path when FACCEL_IRQ_EN is defined.
module tb_faccel_p;

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic        we  = 1'b0;
  logic [1:0]  a   = 2'd0;
  logic [3:0]  d   = 4'd0;
  logic [31:0] out;
`ifdef FACCEL_IRQ_EN
  logic        irq;
`endif

  int pass  = 0;
  int total = 0;
  logic [31:0] v;

  faccel_p #(.NW(4), .OW(32)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .we  (we),
    .a   (a),
    .d   (d),
`ifdef FACCEL_IRQ_EN
    .irq (irq),
`endif
    .out (out)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass++;
    else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic rd(input logic [1:0] ad, output logic [31:0] rv);
    a  = ad;
    #1;
    rv = out;
  endtask

  // drives one bus write; returns at the negedge after the write edge
  task automatic wr(input logic [1:0] ad, input logic [3:0] dv);
    we = 1'b1;
    a  = ad;
    d  = dv;
    @(negedge Clk);
    we = 1'b0;
    d  = 4'd0;
  endtask

  task automatic step(input int cycles);
    repeat (cycles) @(negedge Clk);
  endtask

  task automatic wait_done(input string tag, input int budget);
    logic [31:0] s;
    s = 32'd0;
    for (int i = 0; i < budget; i++) begin
      rd(2'd2, s);
      if (s[0]) break;
      @(negedge Clk);
    end
    check(tag, {31'd0, s[0]}, 32'd1);
  endtask

  initial begin
    // reset state
    #2;
    rd(2'd0, v); check("rst_n", v, 0);
    rd(2'd1, v); check("rst_ctrl", v, 0);
    rd(2'd2, v); check("rst_status", v, 0);
    rd(2'd3, v); check("rst_result", v, 0);
`ifdef FACCEL_IRQ_EN
    check("rst_irq", {31'd0, irq}, 0);
`endif
    step(2);
    Rst = 1'b1;
    step(1);

    // N=5: cycle-exact completion
    wr(2'd0, 4'd5);
    rd(2'd0, v); check("n_rw", v, 5);
    wr(2'd1, 4'd1);
    rd(2'd1, v); check("n5_busy", v, 1);
    step(5);
    rd(2'd2, v); check("n5_status_c5", v, 2);
    step(1);
    rd(2'd2, v); check("n5_status_c6", v, 1);
    rd(2'd3, v); check("n5_result", v, 120);
    rd(2'd1, v); check("n5_idle", v, 0);

    // N=0 and N=1, no clear in between
    wr(2'd0, 4'd0);
    wr(2'd1, 4'd1);
    step(1);
    rd(2'd2, v); check("n0_status_c1", v, 2);
    step(1);
    rd(2'd2, v); check("n0_status_c2", v, 1);
    rd(2'd3, v); check("n0_result", v, 1);
    wr(2'd0, 4'd1);
    wr(2'd1, 4'd1);
    step(1);
    rd(2'd2, v); check("n1_status_c1", v, 2);
    // STATUS clear lands on the completing edge
    wr(2'd2, 4'd1);
    rd(2'd2, v); check("clr_vs_done", v, 1);
    rd(2'd3, v); check("n1_result", v, 1);
    wr(2'd2, 4'd1);
    rd(2'd2, v); check("clr_status", v, 0);

    // largest in-range and first overflowing N for OW=32
    wr(2'd0, 4'd12);
    wr(2'd1, 4'd1);
    wait_done("n12_done", 30);
    rd(2'd2, v); check("n12_status", v, 1);
    rd(2'd3, v); check("n12_result", v, 479001600);
    wr(2'd0, 4'd13);
    wr(2'd1, 4'd1);
    wait_done("n13_done", 30);
    rd(2'd2, v); check("n13_status", v, 5);
    rd(2'd3, v); check("n13_result", v, 0);

    // ignored go and N rewrite mid-run
    wr(2'd0, 4'd7);
    wr(2'd1, 4'd1);
    step(2);
    wr(2'd1, 4'd1);
    wr(2'd0, 4'd3);
    step(3);
    rd(2'd2, v); check("n7_status_c7", v, 2);
    step(1);
    rd(2'd2, v); check("n7_status_c8", v, 1);
    rd(2'd3, v); check("n7_result", v, 5040);
    rd(2'd0, v); check("n7_nreg", v, 3);

    // ie stored without go; clear holds RESULT
    wr(2'd1, 4'd2);
    rd(2'd1, v); check("ie_set", v, 2);
    rd(2'd2, v); check("ie_no_go", v, 1);
    wr(2'd1, 4'd0);
    rd(2'd1, v); check("ie_clr", v, 0);
    wr(2'd2, 4'd1);
    rd(2'd2, v); check("clr2_status", v, 0);
    rd(2'd3, v); check("result_hold", v, 5040);

`ifdef FACCEL_IRQ_EN
    wr(2'd0, 4'd4);
    wr(2'd1, 4'd3);
    rd(2'd1, v); check("irq_ctrl", v, 3);
    step(4);
    check("irq_early", {31'd0, irq}, 0);
    step(1);
    check("irq_rise", {31'd0, irq}, 1);
    rd(2'd2, v); check("irq_done", v, 1);
    rd(2'd3, v); check("irq_result", v, 24);
    wr(2'd2, 4'd1);
    check("irq_clr", {31'd0, irq}, 0);
    rd(2'd2, v); check("irq_clr_status", v, 0);
    wr(2'd1, 4'd1);
    wait_done("irq_ie0_done", 20);
    check("irq_ie0", {31'd0, irq}, 0);
`endif

    // asynchronous reset mid-run
    wr(2'd0, 4'd5);
    wr(2'd1, 4'd3);
    step(2);
    Rst = 1'b0;
    #1;
    rd(2'd0, v); check("arst_n", v, 0);
    rd(2'd1, v); check("arst_ctrl", v, 0);
    rd(2'd2, v); check("arst_status", v, 0);
    rd(2'd3, v); check("arst_result", v, 0);
`ifdef FACCEL_IRQ_EN
    check("arst_irq", {31'd0, irq}, 0);
`endif
    step(2);
    Rst = 1'b1;
    step(10);
    rd(2'd2, v); check("arst_no_done", v, 0);
`ifdef FACCEL_IRQ_EN
    check("arst_irq_after", {31'd0, irq}, 0);
`endif

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
